reg_writeback_queue: RTL and testbench
======================================

// Module: reg_writeback_queue
// PURPOSE
//   Write-side companion of the 16x16 register file. Accepts writeback results from the ALU and the
//   multiply/divide units, buffers them in a small FIFO, and drives the register file write ports at
//   most one entry per clock. Also provides read-after-write forwarding of pending results to the
//   operand-fetch stage, so reads never see stale register file contents.
// PARAMETERS
//   DEPTH  4   FIFO entries, power of two, 2..16
//   DW     16  data width, matches the register file
// PORTS
//   CLOCK       in   1      single clock; all state changes on the rising edge
//   CLEAR       in   1      synchronous, active-high reset
//   req_valid   in   1      writeback request present
//   req_ready   out  1      queue can accept; equals (count < DEPTH)
//   req_kind    in   2      00 no write, 01 port1, 10 port1+port2, 11 port1+R15 (mul/div hi/rem)
//   req_a1      in   4      port1 destination register
//   req_a2      in   4      port2 destination register; ignored unless kind==10
//   req_d1      in   DW     port1 data
//   req_d2      in   DW     port2 data
//   req_d15     in   DW     R15 data; ignored unless kind==11
//   rf_hold     in   1      register file busy; inhibits issue
//   rf_wa1      out  4      register file write address, port1
//   rf_wa2      out  4      register file write address, port2
//   rf_w1       out  DW     write data, port1
//   rf_w2       out  DW     write data, port2
//   rf_w15      out  DW     write data, R15
//   rf_dst      out  2      write-enable code, same encoding as req_kind; 00 means no write this cycle
//   fwd_q1      in   4      forwarding query address, operand A
//   fwd_q2      in   4      forwarding query address, operand B
//   fwd_hit1    out  1      a pending write to fwd_q1 exists
//   fwd_hit2    out  1      a pending write to fwd_q2 exists
//   fwd_d1      out  DW     youngest pending data for fwd_q1; 0 when no hit
//   fwd_d2      out  DW     youngest pending data for fwd_q2; 0 when no hit
//   wb_pending  out  clog2(DEPTH)+1  FIFO occupancy
// BEHAVIOUR
//   - Reset (CLEAR=1 at an edge): FIFO emptied; count=0; rf_dst=00; rf_wa*/rf_w*=0; fwd_* outputs 0.
//     Reset takes priority over a simultaneous push or issue, and discards any in-flight entry.
//   - Push: accepted at an edge when req_valid && req_ready && kind!=00. kind==00 requests are
//     handshaken but not stored. req_ready is based on count only, so a full queue refuses a push even
//     in a cycle where it pops.
//   - Issue: at each edge with rf_hold=0 and count>0, the head entry moves to the output register
//     (rf_*). It is then pushed out to the register file, which writes it on the following edge.
//     Otherwise rf_dst=00 for the next cycle.
//   - Latency: a request pushed into an empty queue at edge N drives rf_* during cycle N+1..N+2;
//     the register file writes it at edge N+2.
//   - A push and an issue in the same edge leave count unchanged. Pointers wrap modulo DEPTH.
//     Entries issue strictly in push order.
//   - Forwarding (combinational):
//     * Searches the output register first, then FIFO entries from youngest to oldest.
//     * An entry matches q when: kind!=00 and a1==q; or kind==10 and a2==q; or kind==11 and q==15.
//     * Priority within one entry: R15 over port2 over port1.
//     * The youngest match supplies fwd_d.
//     * An entry drops out of forwarding once the register file has written it.
//   - rf_hold asserted mid-stream freezes the queue. The output register clears to dst=00 after one
//     cycle; no entry is lost or duplicated.
// TESTING
//   - Reset: CLEAR=1 for 2 cycles with req_valid=1 -> wb_pending=0, rf_dst=00, req_ready=1 afterwards.
//   - Single write: kind=01, a1=3, d1=16'hBEEF into an empty queue at edge N ->
//     rf_dst=01, rf_wa1=3, rf_w1=BEEF after edge N+1; rf_dst=00 after edge N+2.
//   - Full/backpressure: rf_hold=1, push 5 requests -> req_ready=0 after 4 pushes, wb_pending=4;
//     release hold -> 4 writes issued in push order, one per cycle.
//   - Forwarding: push a1=5,d1=1111, then a1=5,d1=2222, with rf_hold=1; fwd_q1=5 -> fwd_hit1=1,
//     fwd_d1=2222. Also kind=11, d15=ABCD with fwd_q2=15 -> fwd_hit2=1, fwd_d2=ABCD.
//   - Simultaneous push+issue at count=2 for 6 cycles -> wb_pending stays 2 and pointers wrap;
//     the data sequence at rf_w1 matches the push order.
//   - Reset mid-operation: CLEAR=1 with 3 entries pending -> no further rf_dst!=00 and all fwd_hit=0.

Source files
------------

// File: rtl/reg_writeback_queue.sv
// reg_writeback_queue
//   Write-side companion of the 16x16 register file. Buffers ALU and mul/div
//   writeback results in a DEPTH-entry FIFO, issues at most one entry per
//   clock into an output register that drives the register file write ports,
//   and forwards pending (not yet written) results to operand fetch.
//
// Ports
//   i_clock, i_clear          clock, synchronous active-high reset
//   i_req_valid/o_req_ready   push handshake (ready = count < DEPTH)
//   i_req_kind                00 none, 01 port1, 10 port1+port2, 11 port1+R15
//   i_req_a1/a2, d1/d2/d15    destination addresses and data
//   i_rf_hold                 register file busy, inhibits issue
//   o_rf_wa1/wa2, w1/w2/w15   register file write address/data
//   o_rf_dst                  write-enable code (kind encoding), 00 = idle
//   i_fwd_q1/q2               forwarding query addresses
//   o_fwd_hit1/2, o_fwd_d1/2  youngest pending match and its data
//   o_wb_pending              FIFO occupancy
module reg_writeback_queue #(
    parameter int DEPTH = 4,
    parameter int DW    = 16
) (
    input  logic                     i_clock,
    input  logic                     i_clear,
    input  logic                     i_req_valid,
    output logic                     o_req_ready,
    input  logic [1:0]               i_req_kind,
    input  logic [3:0]               i_req_a1,
    input  logic [3:0]               i_req_a2,
    input  logic [DW-1:0]            i_req_d1,
    input  logic [DW-1:0]            i_req_d2,
    input  logic [DW-1:0]            i_req_d15,
    input  logic                     i_rf_hold,
    output logic [3:0]               o_rf_wa1,
    output logic [3:0]               o_rf_wa2,
    output logic [DW-1:0]            o_rf_w1,
    output logic [DW-1:0]            o_rf_w2,
    output logic [DW-1:0]            o_rf_w15,
    output logic [1:0]               o_rf_dst,
    input  logic [3:0]               i_fwd_q1,
    input  logic [3:0]               i_fwd_q2,
    output logic                     o_fwd_hit1,
    output logic                     o_fwd_hit2,
    output logic [DW-1:0]            o_fwd_d1,
    output logic [DW-1:0]            o_fwd_d2,
    output logic [$clog2(DEPTH):0]   o_wb_pending
);
    localparam int PW = $clog2(DEPTH);

    typedef struct packed {
        logic [1:0]    kind;
        logic [3:0]    a1;
        logic [3:0]    a2;
        logic [DW-1:0] d1;
        logic [DW-1:0] d2;
        logic [DW-1:0] d15;
    } entry_t;

    entry_t        r_mem [DEPTH];
    entry_t        r_out;
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [PW:0]   r_count;

    entry_t        w_req;
    logic          w_push;
    logic          w_pop;

    assign w_req = '{kind: i_req_kind, a1: i_req_a1, a2: i_req_a2,
                     d1: i_req_d1, d2: i_req_d2, d15: i_req_d15};

    // Ready depends on count only: a full queue refuses even while popping.
    assign o_req_ready = (r_count < (PW+1)'(DEPTH));
    assign w_push      = i_req_valid && o_req_ready && (i_req_kind != 2'b00);
    assign w_pop       = !i_rf_hold && (r_count != '0);

    // Storage needs no reset: only entries below r_count are ever observed.
    always_ff @(posedge i_clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_req;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_clear) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_out    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            // The output register holds an entry for exactly one cycle, the
            // cycle in which the register file writes it.
            if (w_pop) begin
                r_out    <= r_mem[r_rd_ptr];
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end else begin
                r_out    <= '0;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rf_dst     = r_out.kind;
    assign o_rf_wa1     = r_out.a1;
    assign o_rf_wa2     = r_out.a2;
    assign o_rf_w1      = r_out.d1;
    assign o_rf_w2      = r_out.d2;
    assign o_rf_w15     = r_out.d15;
    assign o_wb_pending = r_count;

    // Match one entry against a query; returns {hit, data}. Within an entry
    // R15 beats port2 beats port1.
    function automatic logic [DW:0] probe(input entry_t e, input logic [3:0] q);
        logic [DW:0] res;
        res = '0;
        if (e.kind == 2'b11 && q == 4'd15)      res = {1'b1, e.d15};
        else if (e.kind == 2'b10 && e.a2 == q)  res = {1'b1, e.d2};
        else if (e.kind != 2'b00 && e.a1 == q)  res = {1'b1, e.d1};
        return res;
    endfunction

    logic [1:0][3:0]    w_q;
    logic [1:0]         w_hit;
    logic [1:0][DW-1:0] w_fd;

    assign w_q        = {i_fwd_q2, i_fwd_q1};
    assign o_fwd_hit1 = w_hit[0];
    assign o_fwd_hit2 = w_hit[1];
    assign o_fwd_d1   = w_fd[0];
    assign o_fwd_d2   = w_fd[1];

    // Scan oldest (output register) to youngest FIFO entry; later matches
    // override earlier ones so the youngest pending write wins.
    for (genvar p = 0; p < 2; p++) begin : g_fwd
        logic [DW:0] w_pr;
        always_comb begin
            w_hit[p] = 1'b0;
            w_fd[p]  = '0;
            w_pr     = probe(r_out, w_q[p]);
            if (w_pr[DW]) begin
                w_hit[p] = 1'b1;
                w_fd[p]  = w_pr[DW-1:0];
            end
            for (int i = 0; i < DEPTH; i++) begin
                if ((PW+1)'(i) < r_count) begin
                    w_pr = probe(r_mem[r_rd_ptr + PW'(i)], w_q[p]);
                    if (w_pr[DW]) begin
                        w_hit[p] = 1'b1;
                        w_fd[p]  = w_pr[DW-1:0];
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_reg_writeback_queue.sv
module tb_reg_writeback_queue;
    logic        clk = 1'b0;
    logic        clear = 1'b0, valid = 1'b0, hold = 1'b0;
    logic        ready;
    logic [1:0]  kind = '0;
    logic [3:0]  a1 = '0, a2 = '0, q1 = '0, q2 = '0;
    logic [15:0] d1 = '0, d2 = '0, d15 = '0;
    logic [3:0]  wa1, wa2;
    logic [15:0] w1, w2, w15, fd1, fd2;
    logic [1:0]  dst;
    logic        hit1, hit2;
    logic [2:0]  pending;
    int          total = 0, passed = 0;

    reg_writeback_queue #(.DEPTH(4), .DW(16)) dut (
        .i_clock(clk), .i_clear(clear), .i_req_valid(valid), .o_req_ready(ready),
        .i_req_kind(kind), .i_req_a1(a1), .i_req_a2(a2), .i_req_d1(d1),
        .i_req_d2(d2), .i_req_d15(d15), .i_rf_hold(hold),
        .o_rf_wa1(wa1), .o_rf_wa2(wa2), .o_rf_w1(w1), .o_rf_w2(w2), .o_rf_w15(w15),
        .o_rf_dst(dst), .i_fwd_q1(q1), .i_fwd_q2(q2), .o_fwd_hit1(hit1),
        .o_fwd_hit2(hit2), .o_fwd_d1(fd1), .o_fwd_d2(fd2), .o_wb_pending(pending)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic push(input logic [1:0] k, input logic [3:0] x1, input logic [3:0] x2,
                        input logic [15:0] y1, input logic [15:0] y2, input logic [15:0] y15);
        kind = k; a1 = x1; a2 = x2; d1 = y1; d2 = y2; d15 = y15; valid = 1'b1;
        tick();
        valid = 1'b0;
    endtask

    initial begin
        // Reset with a request presented
        #1;
        clear = 1'b1; valid = 1'b1; kind = 2'b01; a1 = 4'd4; d1 = 16'h0055;
        tick(); tick();
        clear = 1'b0; valid = 1'b0; q1 = 4'd4;
        #1;
        chk("rst_pending", pending, 0);
        chk("rst_dst", dst, 0);
        chk("rst_ready", ready, 1);
        chk("rst_wa1", wa1, 0);
        chk("rst_w1", w1, 0);
        chk("rst_hit1", hit1, 0);

        // kind 00 handshakes but stores nothing
        push(2'b00, 4'd3, 4'd0, 16'h1234, 16'h0, 16'h0);
        chk("k0_pending", pending, 0);
        tick();
        chk("k0_dst", dst, 0);

        // Single write: latency through the output register
        push(2'b01, 4'd3, 4'd0, 16'hBEEF, 16'h0, 16'h0);
        chk("single_pending", pending, 1);
        chk("single_dst_early", dst, 0);
        q1 = 4'd3;
        tick();
        chk("single_dst", dst, 2'b01);
        chk("single_wa1", wa1, 3);
        chk("single_w1", w1, 16'hBEEF);
        chk("single_pending0", pending, 0);
        chk("single_fwd_hit", hit1, 1);
        chk("single_fwd_d", fd1, 16'hBEEF);
        tick();
        chk("single_dst_idle", dst, 0);
        chk("single_fwd_gone", hit1, 0);

        // Full / backpressure
        hold = 1'b1;
        for (int i = 0; i < 5; i++) begin
            kind = 2'b01; a1 = 4'(i); d1 = 16'h0100 + 16'(i); valid = 1'b1;
            #1;
            chk("full_ready", ready, (i < 4) ? 1 : 0);
            tick();
        end
        valid = 1'b0;
        chk("full_pending", pending, 4);
        chk("full_ready_low", ready, 0);
        chk("full_dst_held", dst, 0);
        hold = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("drain_dst", dst, 2'b01);
            chk("drain_w1", w1, 16'h0100 + i);
            chk("drain_wa1", wa1, i);
            chk("drain_pending", pending, 3 - i);
        end
        tick();
        chk("drain_idle", dst, 0);

        // Forwarding
        hold = 1'b1;
        push(2'b01, 4'd5, 4'd0, 16'h1111, 16'h0, 16'h0);
        push(2'b01, 4'd5, 4'd0, 16'h2222, 16'h0, 16'h0);
        push(2'b11, 4'd7, 4'd0, 16'h7777, 16'h0, 16'hABCD);
        q1 = 4'd5; q2 = 4'd15;
        #1;
        chk("fwd_hit1_young", hit1, 1);
        chk("fwd_d1_young", fd1, 16'h2222);
        chk("fwd_hit2_r15", hit2, 1);
        chk("fwd_d2_r15", fd2, 16'hABCD);
        push(2'b10, 4'd8, 4'd5, 16'h8888, 16'h5555, 16'h0);
        q2 = 4'd9;
        #1;
        chk("fwd_d1_port2", fd1, 16'h5555);
        chk("fwd_hit2_miss", hit2, 0);
        chk("fwd_d2_miss", fd2, 0);
        hold = 1'b0;
        tick();
        chk("fwd_issue_w1", w1, 16'h1111);
        chk("fwd_still_young", fd1, 16'h5555);
        tick(); tick(); tick();
        chk("fwd_out_dst", dst, 2'b10);
        chk("fwd_out_wa2", wa2, 5);
        chk("fwd_out_w2", w2, 16'h5555);
        chk("fwd_out_hit", hit1, 1);
        chk("fwd_out_d", fd1, 16'h5555);
        chk("fwd_out_pending", pending, 0);
        tick();
        chk("fwd_written_dst", dst, 0);
        chk("fwd_written_hit", hit1, 0);

        // Simultaneous push + issue at count 2, pointers wrap
        hold = 1'b1;
        push(2'b01, 4'd1, 4'd0, 16'h00A0, 16'h0, 16'h0);
        push(2'b01, 4'd1, 4'd0, 16'h00A1, 16'h0, 16'h0);
        hold = 1'b0;
        for (int k = 0; k < 6; k++) begin
            kind = 2'b01; a1 = 4'd1; d1 = 16'h00A2 + 16'(k); valid = 1'b1;
            tick();
            chk("pp_w1", w1, 16'h00A0 + k);
            chk("pp_pending", pending, 2);
        end
        valid = 1'b0;
        tick();
        chk("pp_tail6", w1, 16'h00A6);
        chk("pp_pending1", pending, 1);
        tick();
        chk("pp_tail7", w1, 16'h00A7);
        chk("pp_pending0", pending, 0);
        tick();

        // Reset mid-operation
        hold = 1'b1;
        push(2'b01, 4'd2, 4'd0, 16'h00C0, 16'h0, 16'h0);
        push(2'b01, 4'd2, 4'd0, 16'h00C1, 16'h0, 16'h0);
        push(2'b01, 4'd2, 4'd0, 16'h00C2, 16'h0, 16'h0);
        q1 = 4'd2;
        #1;
        chk("mid_pending3", pending, 3);
        chk("mid_hit_pre", hit1, 1);
        chk("mid_d_pre", fd1, 16'h00C2);
        clear = 1'b1; hold = 1'b0;
        tick();
        clear = 1'b0;
        chk("mid_pending0", pending, 0);
        chk("mid_hit_post", hit1, 0);
        for (int i = 0; i < 3; i++) begin
            chk("mid_dst_quiet", dst, 0);
            chk("mid_hit_quiet", hit1, 0);
            tick();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
